// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle add/sub/mult sequencer for the 3-bit board ALU
//
// Purpose: accepts one operation at a time over a valid/ready handshake.
// Add and sub finish in one execute cycle. Both multiplies run an iterative
// shift-and-add over the shared adder, one operand bit per cycle. The result
// is held until the consumer acknowledges it.
//
// Ports:
//   clk_2      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  sequencer idle and able to accept a request
//   req_a      in   operand A [NBITS_INT]
//   req_b      in   operand B [NBITS_INT]
//   req_op     in   opcode: 00 add, 01 sub, 10 unsigned mult, 11 signed mult
//   res_valid  out  result and overflow valid
//   res_ready  in   consumer accepts the result
//   res_data   out  result [NBITS_RES]
//   res_ovf    out  signed overflow (add/sub only)
//   busy       out  high in any state other than IDLE
//   op_count   out  count of acknowledged operations, wraps
module alu_op_sequencer #(
  parameter int NBITS_INT  = 3,
  parameter int NBITS_RES  = 6,
  parameter int NBITS_OPER = 2,
  parameter int NBITS_CNT  = 8
) (
  input  logic                  clk_2,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [NBITS_INT-1:0]  req_a,
  input  logic [NBITS_INT-1:0]  req_b,
  input  logic [NBITS_OPER-1:0] req_op,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [NBITS_RES-1:0]  res_data,
  output logic                  res_ovf,
  output logic                  busy,
  output logic [NBITS_CNT-1:0]  op_count
);

  localparam int CW  = $clog2(NBITS_INT);
  localparam int EXT = NBITS_RES - NBITS_INT;

  localparam logic [NBITS_INT-1:0] INT_ONE = 1;
  localparam logic [NBITS_RES-1:0] RES_ONE = 1;
  localparam logic [NBITS_CNT-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0]        CW_ONE  = 1;
  localparam logic [CW-1:0]        CNT_LAST = CW'(NBITS_INT - 1);

  localparam logic [NBITS_OPER-1:0] OP_ADD  = 2'b00;
  localparam logic [NBITS_OPER-1:0] OP_SUB  = 2'b01;
  localparam logic [NBITS_OPER-1:0] OP_UMUL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MULT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [NBITS_INT-1:0]  a_q, a_d;
  logic [NBITS_INT-1:0]  b_q, b_d;
  logic [NBITS_OPER-1:0] op_q, op_d;
  logic [NBITS_INT-1:0]  a_mag_q, a_mag_d;
  logic [NBITS_INT-1:0]  b_mag_q, b_mag_d;
  logic                  neg_q, neg_d;
  logic [NBITS_RES-1:0]  acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NBITS_RES-1:0]  res_q, res_d;
  logic                  ovf_q, ovf_d;
  logic [NBITS_CNT-1:0]  opcnt_q, opcnt_d;

  // Datapath helpers
  logic [NBITS_INT-1:0] sum_w, diff_w;
  logic [NBITS_INT-1:0] a_abs_w, b_abs_w;
  logic [NBITS_RES-1:0] addend_w, acc_nxt_w;

  always_comb begin
    sum_w   = a_q + b_q;
    diff_w  = a_q - b_q;
    // Two's-complement magnitude; the most negative value maps to its
    // unsigned magnitude (100 -> 4), which is why the magnitude is unsigned.
    a_abs_w = a_q[NBITS_INT-1] ? (~a_q + INT_ONE) : a_q;
    b_abs_w = b_q[NBITS_INT-1] ? (~b_q + INT_ONE) : b_q;
    addend_w  = b_mag_q[cnt_q] ? ({{EXT{1'b0}}, a_mag_q} << cnt_q) : '0;
    acc_nxt_w = acc_q + addend_w;
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      a_mag_q <= '0;
      b_mag_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      opcnt_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      opcnt_q <= opcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    opcnt_d = opcnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          op_d    = req_op;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (op_q == OP_ADD) begin
          res_d   = {{EXT{sum_w[NBITS_INT-1]}}, sum_w};
          // Same-sign operands producing an opposite-sign result.
          ovf_d   = (a_q[NBITS_INT-1] == b_q[NBITS_INT-1]) &&
                    (sum_w[NBITS_INT-1] != a_q[NBITS_INT-1]);
          state_d = S_DONE;
        end else if (op_q == OP_SUB) begin
          res_d   = {{EXT{diff_w[NBITS_INT-1]}}, diff_w};
          ovf_d   = (a_q[NBITS_INT-1] != b_q[NBITS_INT-1]) &&
                    (diff_w[NBITS_INT-1] != a_q[NBITS_INT-1]);
          state_d = S_DONE;
        end else begin
          if (op_q == OP_UMUL) begin
            a_mag_d = a_q;
            b_mag_d = b_q;
            neg_d   = 1'b0;
          end else begin
            a_mag_d = a_abs_w;
            b_mag_d = b_abs_w;
            neg_d   = a_q[NBITS_INT-1] ^ b_q[NBITS_INT-1];
          end
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_MULT;
        end
      end

      S_MULT: begin
        acc_d = acc_nxt_w;
        cnt_d = cnt_q + CW_ONE;
        // The last bit's partial product is folded in the same cycle the
        // result is loaded, so the multiply takes exactly NBITS_INT cycles.
        if (cnt_q == CNT_LAST) begin
          res_d   = neg_q ? (~acc_nxt_w + RES_ONE) : acc_nxt_w;
          ovf_d   = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (res_ready) begin
          opcnt_d = opcnt_q + CNT_ONE;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign res_data  = res_q;
  assign res_ovf   = ovf_q;
  assign op_count  = opcnt_q;

endmodule
